// File: rtl/vga_score_pkg.sv
// Shared constants for the VGA score renderer: segment indices, glyph table,
// colours, conversion FSM encoding and BCD accumulator sizing.
package vga_score_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Bit n of each entry lights segment n (SEG_A = bit 0 ... SEG_G = bit 6).
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [7:0] COL_BLACK    = 8'b0000_0000;
    localparam logic [7:0] COL_SCORE_FG = 8'b0001_1101;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    // Decimal digits of the largest score plus one spare nibble, never fewer than digits.
    function automatic int bcd_nibbles(input int score_w, input int digits);
        int v;
        int n;
        v = (1 << score_w) - 1;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            if (v >= 10) begin
                v = v / 10;
                n = n + 1;
            end
        end
        n = n + 1;
        return (n > digits) ? n : digits;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to seven-segment mask; codes above 9 light nothing.
module seg7_decode
    import vga_score_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        seg = 7'd0;
        if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/vga_score_digits.sv
// Multi-digit seven-segment score overlay with per-frame double-dabble conversion.
// Define VGA_SCORE_LZB_EN to blank leading zeros.
module vga_score_digits
    import vga_score_pkg::*;
#(
    parameter int         SCORE_W = 7,
    parameter int         DIGITS  = 2,
    parameter int         X0      = 520,
    parameter int         Y0      = 330,
    parameter int         SEG_LEN = 20,
    parameter int         SEG_TH  = 4,
    parameter int         GAP     = 8,
    parameter logic [7:0] FG      = COL_SCORE_FG,
    parameter logic [7:0] BG      = COL_BLACK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               frame_start,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               video_on,
    output logic [7:0]         rgb,
    output logic               busy,
    output logic               overflow
);

    localparam int NB    = bcd_nibbles(SCORE_W, DIGITS);
    localparam int AW    = 4 * NB;
    localparam int DW    = AW + SCORE_W;
    localparam int CW    = $clog2(SCORE_W + 1);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W     = SEG_LEN + 2 * SEG_TH;
    localparam int H     = 2 * SEG_LEN + 3 * SEG_TH;
    localparam int PITCH = W + GAP;

    conv_state_t       state;
    logic [DW-1:0]     dd;          // {BCD accumulator, shadow score}, shifted left together
    logic [DW-1:0]     dd_adj;
    logic [CW-1:0]     cnt;
    logic [3:0]        disp [DIGITS];
    logic [DIGITS-1:0] blank;

    logic              upper_nz;
    logic [3:0]        commit_dig [DIGITS];
    logic [DIGITS-1:0] commit_blank;

    always_comb begin
        dd_adj = dd;
        for (int i = 0; i < NB; i++) begin
            if (dd[SCORE_W + 4*i +: 4] >= 4'd5)
                dd_adj[SCORE_W + 4*i +: 4] = dd[SCORE_W + 4*i +: 4] + 4'd3;
        end
    end

    // Any nonzero nibble above the displayed ones means the value does not fit.
    always_comb begin
        upper_nz = 1'b0;
        for (int i = DIGITS; i < NB; i++)
            upper_nz = upper_nz | (dd[SCORE_W + 4*i +: 4] != 4'd0);
        for (int k = 0; k < DIGITS; k++)
            commit_dig[k] = upper_nz ? 4'd9 : dd[SCORE_W + 4*(DIGITS-1-k) +: 4];
    end

`ifdef VGA_SCORE_LZB_EN
    always_comb begin
        logic lead;
        lead         = 1'b1;
        commit_blank = '0;
        for (int k = 0; k < DIGITS; k++) begin
            lead = lead & (commit_dig[k] == 4'd0);
            if (k < DIGITS - 1) commit_blank[k] = lead;
        end
    end
`else
    assign commit_blank = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dd       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            blank    <= '0;
            // NOTE: the display digits are few and must read 0 after reset, so they are reset like any register.
            for (int k = 0; k < DIGITS; k++) disp[k] <= 4'd0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        dd    <= {{AW{1'b0}}, score};
                        cnt   <= CW'(SCORE_W);
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    dd  <= dd_adj << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    for (int k = 0; k < DIGITS; k++) disp[k] <= commit_dig[k];
                    blank    <= commit_blank;
                    overflow <= upper_nz;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic          hit_n;
    logic [IW-1:0] idx_n;
    logic [9:0]    lx_n;
    logic [9:0]    ly_n;

    always_comb begin
        int px;
        int py;
        int base;
        px    = int'(pixel_x);
        py    = int'(pixel_y);
        base  = X0;
        hit_n = 1'b0;
        idx_n = '0;
        lx_n  = '0;
        ly_n  = 10'(py - Y0);
        for (int k = 0; k < DIGITS; k++) begin
            base = X0 + k * PITCH;
            if (px >= base && px < base + W) begin
                hit_n = 1'b1;
                idx_n = IW'(k);
                lx_n  = 10'(px - base);
            end
        end
        if (py < Y0 || py >= Y0 + H) hit_n = 1'b0;
    end

    logic          s1_in;
    logic          s1_von;
    logic [IW-1:0] s1_idx;
    logic [9:0]    s1_lx;
    logic [9:0]    s1_ly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_in  <= 1'b0;
            s1_von <= 1'b0;
            s1_idx <= '0;
            s1_lx  <= '0;
            s1_ly  <= '0;
        end else begin
            s1_in  <= hit_n;
            s1_von <= video_on;
            s1_idx <= idx_n;
            s1_lx  <= lx_n;
            s1_ly  <= ly_n;
        end
    end

    logic [3:0] cur_dig;
    logic       cur_blank;
    logic [6:0] seg_mask;
    logic [6:0] seg_hit;
    logic       lit;

    always_comb begin
        cur_dig   = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (s1_idx == IW'(k)) begin
                cur_dig   = disp[k];
                cur_blank = blank[k];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .bcd (cur_dig),
        .seg (seg_mask)
    );

    always_comb begin
        int  lx;
        int  ly;
        logic mid_x, left, right, upper, lower;
        lx    = int'(s1_lx);
        ly    = int'(s1_ly);
        mid_x = (lx >= SEG_TH) && (lx < W - SEG_TH);
        left  = lx < SEG_TH;
        right = lx >= W - SEG_TH;
        upper = (ly >= SEG_TH) && (ly < SEG_LEN + SEG_TH);
        lower = (ly >= SEG_LEN + 2*SEG_TH) && (ly < H - SEG_TH);
        seg_hit        = '0;
        seg_hit[SEG_A] = mid_x && (ly < SEG_TH);
        seg_hit[SEG_G] = mid_x && (ly >= SEG_LEN + SEG_TH) && (ly < SEG_LEN + 2*SEG_TH);
        seg_hit[SEG_D] = mid_x && (ly >= H - SEG_TH);
        seg_hit[SEG_F] = left  && upper;
        seg_hit[SEG_B] = right && upper;
        seg_hit[SEG_E] = left  && lower;
        seg_hit[SEG_C] = right && lower;
        lit = s1_in && !cur_blank && (|(seg_hit & seg_mask));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        rgb <= 8'd0;
        else if (!s1_von)  rgb <= 8'd0;
        else               rgb <= lit ? FG : BG;
    end

endmodule

// File: tb/tb_vga_score_digits.sv
// Self-checking bench for vga_score_digits: random scores and pixels against a
// glyph-level reference model of the rendered overlay.
module tb_vga_score_digits;

    localparam int         SCORE_W = 7;
    localparam int         DIGITS  = 2;
    localparam int         X0      = 520;
    localparam int         Y0      = 330;
    localparam int         SEG_LEN = 20;
    localparam int         SEG_TH  = 4;
    localparam int         GAP     = 8;
    localparam logic [7:0] FG_C    = 8'b0001_1101;
    localparam logic [7:0] BG_C    = 8'b0000_0000;
    localparam int         W       = SEG_LEN + 2*SEG_TH;
    localparam int         H       = 2*SEG_LEN + 3*SEG_TH;
    localparam int         PITCH   = W + GAP;

    logic               clk = 1'b0;
    logic               reset;
    logic [SCORE_W-1:0] score;
    logic               frame_start;
    logic [9:0]         pixel_x;
    logic [9:0]         pixel_y;
    logic               video_on;
    logic [7:0]         rgb;
    logic               busy;
    logic               overflow;

    int errors = 0;
    int checks = 0;

    // Reference state: value currently shown and its saturation flag.
    int m_shown = 0;
    bit m_ovf   = 1'b0;

    always #5 clk = ~clk;

    vga_score_digits #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS),
        .X0      (X0),
        .Y0      (Y0),
        .SEG_LEN (SEG_LEN),
        .SEG_TH  (SEG_TH),
        .GAP     (GAP),
        .FG      (FG_C),
        .BG      (BG_C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .score       (score),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .rgb         (rgb),
        .busy        (busy),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic string glyph(input int d);
        case (d)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic byte seg_at(input int lx, input int ly);
        bit mx = (lx >= SEG_TH) && (lx < W - SEG_TH);
        bit up = (ly >= SEG_TH) && (ly < SEG_TH + SEG_LEN);
        bit lo = (ly >= SEG_LEN + 2*SEG_TH) && (ly < H - SEG_TH);
        if (mx && ly < SEG_TH) return "a";
        if (mx && ly >= SEG_LEN + SEG_TH && ly < SEG_LEN + 2*SEG_TH) return "g";
        if (mx && ly >= H - SEG_TH) return "d";
        if (lx < SEG_TH && up) return "f";
        if (lx >= W - SEG_TH && up) return "b";
        if (lx < SEG_TH && lo) return "e";
        if (lx >= W - SEG_TH && lo) return "c";
        return 8'd0;
    endfunction

    function automatic bit glyph_has(input int d, input byte s);
        string g = glyph(d);
        if (s == 8'd0) return 1'b0;
        for (int i = 0; i < g.len(); i++) if (g[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_blank(input int k);
`ifdef VGA_SCORE_LZB_EN
        return (k < DIGITS - 1) && (m_shown < pow10(DIGITS - 1 - k));
`else
        return (k < 0);
`endif
    endfunction

    function automatic logic [7:0] model_rgb(input int x, input int y, input bit von);
        logic [7:0] c;
        int bx;
        int d;
        if (!von) return 8'h00;
        c = BG_C;
        for (int k = 0; k < DIGITS; k++) begin
            bx = X0 + k * PITCH;
            d  = (m_shown / pow10(DIGITS - 1 - k)) % 10;
            if (x >= bx && x < bx + W && y >= Y0 && y < Y0 + H && !model_blank(k))
                if (glyph_has(d, seg_at(x - bx, y - Y0))) c = FG_C;
        end
        return c;
    endfunction

    task automatic probe(input string tag, input int x, input int y, input bit von);
        logic [7:0] exp;
        @(negedge clk);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        exp = model_rgb(x, y, von);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check(tag, rgb, exp);
    endtask

    task automatic probe_glyphs(input string tag);
        int lx, ly;
        for (int k = 0; k < DIGITS; k++) begin
            for (int p = 0; p < 10; p++) begin
                case (p)
                    0: begin lx = W/2;    ly = SEG_TH/2;                end
                    1: begin lx = W-2;    ly = SEG_TH + SEG_LEN/2;      end
                    2: begin lx = W-2;    ly = H - SEG_TH - SEG_LEN/2;  end
                    3: begin lx = W/2;    ly = H-1;                     end
                    4: begin lx = 1;      ly = H - SEG_TH - SEG_LEN/2;  end
                    5: begin lx = 1;      ly = SEG_TH + SEG_LEN/2;      end
                    6: begin lx = W/2;    ly = SEG_LEN + SEG_TH;        end
                    7: begin lx = 0;      ly = 0;                       end
                    8: begin lx = W/2;    ly = SEG_TH + SEG_LEN/2;      end
                    default: begin lx = W + 1; ly = 0;                  end
                endcase
                probe($sformatf("%s_d%0d_p%0d", tag, k, p), X0 + k*PITCH + lx, Y0 + ly, 1'b1);
            end
        end
    endtask

    task automatic probe_random(input string tag, input int n);
        int x, y;
        bit v;
        for (int i = 0; i < n; i++) begin
            x = X0 - 4 + int'($urandom_range(0, DIGITS*PITCH + 8));
            y = Y0 - 4 + int'($urandom_range(0, H + 8));
            v = ($urandom_range(0, 9) != 0);
            probe($sformatf("%s_rnd%0d", tag, i), x, y, v);
        end
    endtask

    // Pulses frame_start with score s; optionally re-pulses with glitch_s while busy.
    task automatic run_frame(input string tag, input int s, input int glitch_s);
        int n;
        int max_v;
        @(negedge clk);
        score       = SCORE_W'(s);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3 && glitch_s >= 0) begin
                score       = SCORE_W'(glitch_s);
                frame_start = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            @(negedge clk);
        end
        frame_start = 1'b0;
        max_v   = pow10(DIGITS) - 1;
        m_ovf   = (s > max_v);
        m_shown = m_ovf ? max_v : s;
        check({tag, "_busy_cycles"}, n, SCORE_W + 1);
        check({tag, "_overflow"}, overflow, m_ovf);
    endtask

    initial begin
        reset       = 1'b0;
        score       = '0;
        frame_start = 1'b0;
        pixel_x     = '0;
        pixel_y     = '0;
        video_on    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_rgb", rgb, 8'h00);
        probe("reset_outside_blank", 10, 10, 1'b0);
        probe_glyphs("reset_00");

        // Score 37 and the two named pixels
        run_frame("s37", 37, -1);
        probe("s37_seg_a", X0 + SEG_TH + 1, Y0, 1'b1);
        probe("s37_seg_g", X0 + SEG_TH + 1, Y0 + SEG_LEN + SEG_TH, 1'b1);
        probe_glyphs("s37");

        // Score changes without frame_start: display must hold
        @(negedge clk);
        score = SCORE_W'(42);
        repeat (5) @(negedge clk);
        probe_glyphs("hold37");
        run_frame("s42", 42, -1);
        probe_glyphs("s42");

        // Saturation and recovery
        run_frame("s120", 120, -1);
        probe_glyphs("s120");
        run_frame("s5", 5, -1);
        probe_glyphs("s5");
        run_frame("s120b", 120, -1);

        // Reset in the middle of a conversion
        probe("pre_rst_pix", X0 + W - 2, Y0 + SEG_TH + SEG_LEN/2, 1'b1);
        @(negedge clk);
        score       = SCORE_W'(88);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("mid_conv_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_rgb", rgb, 8'h00);
        check("async_rst_overflow", overflow, 1'b0);
        @(negedge clk);
        reset   = 1'b1;
        m_shown = 0;
        m_ovf   = 1'b0;
        probe_glyphs("post_rst_00");

        // Randomised frames, one with an ignored frame_start while busy
        for (int i = 0; i < 6; i++) begin
            int s;
            s = int'($urandom_range(0, (1 << SCORE_W) - 1));
            run_frame($sformatf("rnd%0d", i), s, (i == 1) ? int'($urandom_range(0, (1 << SCORE_W) - 1)) : -1);
            probe_random($sformatf("rnd%0d", i), 30);
        end
        run_frame("s99", 99, -1);
        probe_glyphs("s99");
        run_frame("s100", 100, -1);
        run_frame("s0", 0, -1);
        probe_glyphs("s0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_score_digits.md
Name: vga_score_digits

Overview:
- Parametrised multi-digit decimal score renderer for the VGA path.
- Draws DIGITS seven-segment glyphs at a fixed screen position from a binary score.
- Takes pixel coordinates and video_on from the shared vga_sync unit and outputs an 8-bit rrrgggbb colour.
- Latches the score once per frame. Converts it to BCD with a sequential double-dabble engine, so the displayed value never changes mid-frame.

Parameters:
- SCORE_W, 7, binary score width (1..14)
- DIGITS, 2, number of decimal digits drawn (1..4)
- X0, 520, left pixel column of the most-significant digit box
- Y0, 330, top pixel row of the digit boxes
- SEG_LEN, 20, segment length in pixels
- SEG_TH, 4, segment thickness in pixels
- GAP, 8, horizontal pixels between digit boxes
- FG, 8'b00011101, lit-segment colour
- BG, 8'b00000000, colour of everything else while video_on

Ports:
- clk, in, 1, pixel clock
- reset, in, 1, asynchronous active-low reset
- score, in, SCORE_W, binary score; sampled only at frame_start
- frame_start, in, 1, one-cycle pulse at start of vertical blanking
- pixel_x, in, 10, current pixel column
- pixel_y, in, 10, current pixel row
- video_on, in, 1, active-area flag, aligned with pixel_x/pixel_y
- rgb, out, 8, pixel colour, registered
- busy, out, 1, high while BCD conversion runs
- overflow, out, 1, high while the displayed value is saturated

Behaviour:
- Reset (reset=0, asynchronous): rgb=0, busy=0, overflow=0; display digits=0; FSM=IDLE.
- FSM states:
  - IDLE: on frame_start, load score into shadow register, clear BCD accumulator, counter=SCORE_W; go to CONV, busy=1.
  - CONV: each cycle, add 3 to every BCD nibble >=5, then shift left one bit with the next shadow MSB; decrement counter; at counter=0 go to COMMIT.
  - COMMIT: one cycle. Copy accumulator to display digits atomically; busy=0; go to IDLE.
- Conversion latency: SCORE_W+1 cycles from frame_start to the updated display register.
- frame_start while busy is ignored. The conversion in flight completes unchanged.
- Saturation: if the shadow value >10^DIGITS-1, COMMIT loads all digits with 9 and sets overflow=1. Otherwise overflow=0. Overflow updates only at COMMIT.
- BCD accumulator width is 4*ceil(SCORE_W*log10(2)+1) nibbles, at least DIGITS. Upper nibbles are used only for the overflow check.
- Reset asserted mid-conversion aborts it. After release the display shows 0 until the next completed conversion.
- Glyph geometry:
  - Digit box: width W=SEG_LEN+2*SEG_TH, height H=2*SEG_LEN+3*SEG_TH. Digit k (0 = MSD) spans x in [X0+k*(W+GAP), X0+k*(W+GAP)+W).
  - Local coordinates lx, ly within the box.
  - a: ly<SEG_TH, SEG_TH<=lx<W-SEG_TH
  - g: SEG_LEN+SEG_TH<=ly<SEG_LEN+2*SEG_TH, same lx range
  - d: ly>=H-SEG_TH, same lx range
  - f/b: lx<SEG_TH or lx>=W-SEG_TH, with SEG_TH<=ly<SEG_LEN+SEG_TH
  - e/c: same lx conditions, with SEG_LEN+2*SEG_TH<=ly<H-SEG_TH
- Pixel pipeline, 2 cycles from pixel_x/pixel_y/video_on to rgb:
  - Stage 1 registers digit index, in-box flag, lx, ly, video_on.
  - Stage 2 decodes segments.
  - rgb = FG if video_on_d and a lit segment is hit; BG if video_on_d otherwise; 0 if video_on_d=0.
- Display digits are stable during the active area because conversion runs in vertical blanking. COMMIT changes the display only between pixels, with no partial glyphs.

Optional Feature:
- Macro: VGA_SCORE_LZB_EN.
- Defined: leading-zero blanking. Every digit more significant than the first nonzero digit is blank (BG). The least-significant digit is always drawn. Blanking is computed at COMMIT and stored as a per-digit mask.
- Undefined: all DIGITS digits are always drawn, with leading zeros shown.

Decomposition:
- Shared package vga_score_pkg:
  - segment index constants SEG_A..SEG_G
  - 10-entry digit-to-segment mask table
  - colour constants COL_BLACK and COL_SCORE_FG
  - FSM state encoding (IDLE, CONV, COMMIT)
- One sub-module: seg7_decode, a 4-bit BCD to 7-bit segment mask decoder (combinational, used in stage 2).
- The double-dabble engine stays inline.

Test Plan:
- Reset released, no frame_start -> rgb=0 outside the active area; digits box pixels show segment pattern of "00"; busy=0; overflow=0.
- score=37, frame_start pulse -> busy=1 for exactly 8 cycles (SCORE_W=7 plus COMMIT); digits then 3,7.
  - Pixel (X0+SEG_TH+1, Y0) -> rgb=FG two cycles later.
  - Pixel (X0+SEG_TH+1, Y0+SEG_LEN+SEG_TH) (segment g of "3") -> FG.
- score=120, DIGITS=2 -> display 9,9 and overflow=1. A following frame with score=5 -> display 0,5 and overflow=0.
- score changes 37->42 mid-frame without frame_start -> rgb unchanged. After the next frame_start plus 8 cycles -> glyphs show 42.
- reset pulsed low at cycle 3 of conversion -> busy=0 and rgb=0 immediately (asynchronous); display shows 00 after release.
- With VGA_SCORE_LZB_EN, score=5 -> tens box all BG, units shows 5. Without it -> tens shows 0.
